// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
//
// Types, constants and helpers shared by the BCD up/down counter and its
// per-decade sub-module.
//
// Contents:
//   bcd_digit_t   - one packed BCD decade (4 bits, legal values 0..9)
//   BCD_MAX       - largest legal decade value (9)
//   BCD_MIN       - smallest legal decade value (0)
//   bcd_dir_e     - count direction encoding, matches the up_dn pin
//   bcd_invalid() - true when a 4-bit code is not a legal BCD digit
//   bcd_sanitize()- maps illegal codes (A..F) to BCD_MIN, passes legal ones
// -----------------------------------------------------------------------------
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  // The enum values line up with the up_dn pin so a pin can be compared
  // directly against DIR_UP / DIR_DOWN.
  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } bcd_dir_e;

  // Codes 4'hA..4'hF are not BCD.
  function automatic logic bcd_invalid(input bcd_digit_t d);
    return (d > BCD_MAX);
  endfunction

  // Illegal codes are replaced by zero so the counter can never hold a
  // non-BCD digit, no matter what is presented on the load bus.
  function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t d);
    return bcd_invalid(d) ? BCD_MIN : d;
  endfunction

endpackage : bcd_pkg

// File: rtl/bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
//
// One decade of the cascaded BCD counter.  Holds a single BCD digit and
// advances it by one position in either direction when 'step' is high.
// Going up, 9 rolls to 0; going down, 0 rolls to 9.  The rollover decision
// for the whole counter (wrap versus saturate) is made by the parent, which
// simply withholds 'step' when the counter must hold at its terminal count.
//
// Ports:
//   clk         in   clock, all updates on rising edge
//   rst_n       in   asynchronous active-low reset, clears the digit
//   clr         in   synchronous clear (highest priority)
//   load        in   synchronous load of load_digit (after clr)
//   load_digit  in   [3:0] value to load; non-BCD codes load as 0
//   step        in   advance the digit by one (lowest priority)
//   up_dn       in   direction of the step, 1 = up, 0 = down
//   digit       out  [3:0] registered digit value
//   at_max      out  digit currently equals 9 (ripple-carry condition)
//   at_min      out  digit currently equals 0 (ripple-borrow condition)
// -----------------------------------------------------------------------------
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       step,
  input  logic       up_dn,
  output logic [3:0] digit,
  output logic       at_max,
  output logic       at_min
);

  bcd_digit_t digit_q;
  bcd_digit_t digit_d;

  // Next-digit selection: clear beats load, load beats stepping, and with
  // nothing requested the digit holds.
  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = BCD_MIN;
    end else if (load) begin
      digit_d = bcd_sanitize(load_digit);
    end else if (step) begin
      if (up_dn == DIR_UP) begin
        digit_d = (digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
      end else begin
        digit_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
      end
    end
  end

  // Digit register; reset takes effect immediately, independent of clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= BCD_MIN;
    end else begin
      digit_q <= digit_d;
    end
  end

  // Extremes are decoded from the register only, so the carry/borrow chain
  // in the parent has no path from this digit's own inputs.
  assign digit  = digit_q;
  assign at_max = (digit_q == BCD_MAX);
  assign at_min = (digit_q == BCD_MIN);

endmodule : bcd_digit

// File: rtl/bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// bcd_updown_counter
//
// Multi-decade BCD up/down counter built from DIGITS chained bcd_digit
// instances.  Per cycle the priority is clear, then load, then count.
// Counting ripples a carry (up) or borrow (down) through the decades: a
// decade steps only when every lower decade sits at its extreme for the
// current direction.  At the terminal count (all 9s up, all 0s down) the
// counter either wraps to the opposite extreme (WRAP_EN=1) or holds
// (WRAP_EN=0).
//
// Parameters:
//   DIGITS    number of decades, legal range 1..8
//   WRAP_EN   1 = wrap at terminal count, 0 = saturate
//
// Ports:
//   clk       in   clock, all state changes on rising edge
//   rst_n     in   asynchronous active-low reset
//   clr       in   synchronous clear to zero
//   load      in   synchronous parallel load of load_val
//   load_val  in   [4*DIGITS-1:0] BCD load value, digit 0 in [3:0]
//   en        in   count enable, one step per enabled cycle
//   up_dn     in   direction, 1 = up, 0 = down
//   bcd       out  [4*DIGITS-1:0] registered count
//   tc        out  combinational terminal count / cascade carry
//   wrap      out  registered one-cycle pulse after a wrap
//   load_err  out  registered one-cycle pulse after a load with a non-BCD digit
// -----------------------------------------------------------------------------
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter bit WRAP_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  en,
  input  logic                  up_dn,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  tc,
  output logic                  wrap,
  output logic                  load_err
);

  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_min;
  logic [DIGITS-1:0] step;
  logic [DIGITS-1:0] bad_digit;

  logic count_req;
  logic at_terminal;
  logic step0;
  logic wrap_q;
  logic load_err_q;

  // A count only happens when neither clear nor load claims the cycle.
  assign count_req   = en & ~clr & ~load;

  // Terminal value depends on direction: all 9s going up, all 0s going down.
  assign at_terminal = (up_dn == DIR_UP) ? (&at_max) : (&at_min);

  // tc doubles as the carry-out for cascading counters, so it is purely
  // combinational and is valid in the same cycle as en.
  assign tc          = count_req & at_terminal;

  // In saturate mode the step into digit 0 is suppressed at terminal count,
  // which freezes the whole chain; in wrap mode every digit simply rolls.
  assign step0       = count_req & (WRAP_EN ? 1'b1 : ~at_terminal);

  // Ripple chain and decade instances.  Each decade steps when the decade
  // below it stepped and sits at its extreme for the current direction.
  for (genvar k = 0; k < DIGITS; k++) begin : g_decade
    if (k == 0) begin : g_first
      assign step[k] = step0;
    end else begin : g_rest
      assign step[k] = step[k-1] &
                       ((up_dn == DIR_UP) ? at_max[k-1] : at_min[k-1]);
    end

    assign bad_digit[k] = bcd_invalid(load_val[4*k +: 4]);

    bcd_digit u_digit (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr),
      .load       (load),
      .load_digit (load_val[4*k +: 4]),
      .step       (step[k]),
      .up_dn      (up_dn),
      .digit      (bcd[4*k +: 4]),
      .at_max     (at_max[k]),
      .at_min     (at_min[k])
    );
  end

  // Status pulses.  A wrap happens exactly when tc is high in wrap mode,
  // because tc means "stepping beyond the terminal value this cycle".  A
  // load error is flagged only for loads that actually take effect, so a
  // load overridden by clr does not report.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= WRAP_EN & tc;
      load_err_q <= load & ~clr & (|bad_digit);
    end
  end

  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule : bcd_updown_counter
